// File: rtl/regfile_sb_bypass.sv
// Multi-read-port register file with same-cycle write bypass, pending-write scoreboard
// and a sequential clear engine that zeroes the array after reset or on request.
module regfile_sb_bypass #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [XLEN-1:0]          wd,
  input  logic                     iss_v,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     clr_req,
  output logic                     ready
);

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0]  sb_q, sb_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    sb_d      = sb_q;
    mem_we    = 1'b0;
    mem_wa    = wa;
    mem_wd    = wd;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_wa    = clr_ptr_q;
        mem_wd    = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // A clear request drops any writeback/issue presented alongside it.
        if (clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
          sb_d      = '0;
        end else begin
          if (we && (wa != '0)) begin
            mem_we   = 1'b1;
            sb_d[wa] = 1'b0;
          end
          // Issue applied after retire so a same-address issue wins.
          if (iss_v && (iss_addr != '0)) begin
            sb_d[iss_addr] = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      sb_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      sb_q      <= sb_d;
    end
  end

  // Array is not reset; the clear engine zeroes it before ready rises.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign ready = (state_q == StIdle);

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      if (ready && rd_en[k] && (rd_addr[k*AW +: AW] != '0)) begin
        if (we && (wa == rd_addr[k*AW +: AW])) begin
          rd_data[k*XLEN +: XLEN] = wd;
          rd_pend[k]              = 1'b0;
        end else begin
          rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
          rd_pend[k]              = sb_q[rd_addr[k*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Self-checking bench for regfile_sb_bypass: directed scenarios plus randomized traffic
// compared each cycle against an array-based reference model.
module tb_regfile_sb_bypass;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_RD-1:0]      rd_en = '0;
  logic [NUM_RD*AW-1:0]   rd_addr = '0;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_pend;
  logic                   we = 1'b0;
  logic [AW-1:0]          wa = '0;
  logic [XLEN-1:0]        wd = '0;
  logic                   iss_v = 1'b0;
  logic [AW-1:0]          iss_addr = '0;
  logic                   clr_req = 1'b0;
  logic                   ready;

  regfile_sb_bypass #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_v    (iss_v),
    .iss_addr (iss_addr),
    .clr_req  (clr_req),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, outstanding-write flags, clear cycles remaining.
  logic [XLEN-1:0] m_mem [DEPTH];
  bit              m_sb  [DEPTH];
  int              m_clr_left;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_sb[i]  = 1'b0;
    end
    m_clr_left = DEPTH;
  endtask

  task automatic set_rd(input int k, input bit en, input int a);
    rd_en[k]            = en;
    rd_addr[k*AW +: AW] = a[AW-1:0];
  endtask

  function automatic int pick_addr();
    if ($urandom % 2 == 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic idle_inputs();
    we = 1'b0; iss_v = 1'b0; clr_req = 1'b0; rd_en = '0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    we       = ($urandom % 2) == 0;
    wa       = AW'(pick_addr());
    wd       = $urandom;
    iss_v    = ($urandom % 3) == 0;
    iss_addr = AW'(pick_addr());
    clr_req  = allow_clr && (($urandom % 64) == 0);
    for (int k = 0; k < NUM_RD; k++) set_rd(k, ($urandom % 4) != 0, pick_addr());
  endtask

  // Called just after a falling edge: check outputs for the current inputs, advance the
  // model by one rising edge, and return at the next falling edge.
  task automatic do_cycle();
    bit              rdy;
    int              a;
    bit              hit;
    logic [XLEN-1:0] exp_d;
    bit              exp_p;
    #1;
    rdy = (m_clr_left == 0);
    check_eq("ready", ready, rdy);
    for (int k = 0; k < NUM_RD; k++) begin
      a     = int'(rd_addr[k*AW +: AW]);
      hit   = we && (int'(wa) == a);
      exp_d = '0;
      exp_p = 1'b0;
      if (rdy && rd_en[k] && a != 0) begin
        exp_d = hit ? wd : m_mem[a];
        exp_p = m_sb[a] && !hit;
      end
      check_eq($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], exp_d);
      check_eq($sformatf("rd_pend%0d", k), rd_pend[k], exp_p);
    end
    if (!rdy) begin
      m_clr_left--;
    end else if (clr_req) begin
      model_clear();
    end else begin
      if (we && wa != 0) begin
        m_mem[wa] = wd;
        m_sb[wa]  = 1'b0;
      end
      if (iss_v && iss_addr != 0) m_sb[iss_addr] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle reset pulse from a falling edge; outputs must be quiet while it is low.
  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < NUM_RD; k++) set_rd(k, 1'b1, k + 3);
    #1;
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_rd_pend", rd_pend, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!ready && cnt < 100) begin
      rand_inputs(1'b1);
      do_cycle();
      cnt++;
    end
    check_eq(tag, cnt, DEPTH);
    idle_inputs();
  endtask

  initial begin
    @(negedge clk);

    // Reset and initial clear latency; random writes/issues/clears are ignored meanwhile.
    do_reset();
    wait_ready("t1_ready_latency");
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NUM_RD; k++) set_rd(k, 1'b1, pick_addr());
      do_cycle();
    end

    // Same-cycle bypass, then the array value.
    we = 1'b1; wa = 5; wd = 32'hDEADBEEF; set_rd(0, 1'b1, 5);
    #1 check_eq("t2_bypass", rd_data[XLEN-1:0], 32'hDEADBEEF);
    do_cycle();
    we = 1'b0;
    #1 check_eq("t2_array", rd_data[XLEN-1:0], 32'hDEADBEEF);
    do_cycle();

    // Register 0 stays zero.
    we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; set_rd(0, 1'b1, 0); set_rd(1, 1'b1, 0);
    #1 check_eq("t3_r0_same", rd_data, '0);
    do_cycle();
    we = 1'b0;
    #1 check_eq("t3_r0_next", rd_data, '0);
    do_cycle();

    // Scoreboard: issue, retire with bypass, issue+write collision.
    iss_v = 1'b1; iss_addr = 7; set_rd(0, 1'b1, 7); set_rd(1, 1'b1, 7);
    #1 check_eq("t4_pend_same", rd_pend[0], 1'b0);
    do_cycle();
    iss_v = 1'b0;
    #1 check_eq("t4_pend_next", rd_pend, 2'b11);
    do_cycle();
    we = 1'b1; wa = 7; wd = 9;
    #1 check_eq("t4_retire_pend", rd_pend[0], 1'b0);
    check_eq("t4_retire_data", rd_data[XLEN-1:0], 9);
    do_cycle();
    iss_v = 1'b1; iss_addr = 7; wd = 11;
    do_cycle();
    we = 1'b0; iss_v = 1'b0;
    #1 check_eq("t4_collide_pend", rd_pend[1], 1'b1);
    check_eq("t4_collide_data", rd_data[2*XLEN-1:XLEN], 11);
    do_cycle();

    // Fill, soft clear, writes during clear dropped, then all zero and not pending.
    for (int r = 1; r < DEPTH; r++) begin
      we = 1'b1; wa = AW'(r); wd = r; iss_v = 1'b1; iss_addr = AW'(r ^ 3);
      set_rd(0, 1'b1, r); set_rd(1, 1'b1, r ^ 3);
      do_cycle();
    end
    we = 1'b1; wa = 3; wd = 32'hAA; iss_v = 1'b1; iss_addr = 9; clr_req = 1'b1;
    do_cycle();
    clr_req = 1'b0;
    wait_ready("t5_clear_latency");
    for (int r = 0; r < DEPTH; r += 2) begin
      set_rd(0, 1'b1, r); set_rd(1, 1'b1, r + 1);
      #1 check_eq("t5_zero", rd_data, '0);
      check_eq("t5_nopend", rd_pend, '0);
      do_cycle();
    end

    // Reset in the middle of a clear restarts it.
    clr_req = 1'b1;
    do_cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs(1'b1);
      do_cycle();
    end
    do_reset();
    wait_ready("t6_restart_latency");

    // Randomized traffic with occasional soft clears.
    for (int i = 0; i < 800; i++) begin
      rand_inputs(1'b1);
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
